// File: rtl/pipe_ctrl_regs.sv
// +--------------------------------------------------------------------------+
// | pipe_ctrl_regs : control-side D->E->M->W register chain with mul/div     |
// | hold in E, branch clear of D and a retired-instruction counter.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module pipe_ctrl_regs #(
   parameter int MD_CYCLES = 4,
   parameter int RETIRE_W  = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [4:0]          RsD_i,
   input  logic [4:0]          RtD_i,
   input  logic [4:0]          WriteRegD_i,
   input  logic                RegWriteD_i,
   input  logic                MemtoRegD_i,
   input  logic                MulDivD_i,
   input  logic                StallF_i,
   input  logic                StallD_i,
   input  logic                FlushE_i,
   input  logic                PCSrcD_i,
   output logic [4:0]          RsE_o,
   output logic [4:0]          RtE_o,
   output logic [4:0]          WriteRegE_o,
   output logic                RegWriteE_o,
   output logic                MemtoRegE_o,
   output logic [4:0]          WriteRegM_o,
   output logic                RegWriteM_o,
   output logic                MemtoRegM_o,
   output logic [4:0]          WriteRegW_o,
   output logic                RegWriteW_o,
   output logic                EnF_o,
   output logic                EnD_o,
   output logic                ClrD_o,
   output logic                MdStall_o,
   output logic [RETIRE_W-1:0] RetireCount_o
);

   localparam int CNT_W = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_CYCLES - 1);

   logic [4:0]          RsE_q, RsE_d, RtE_q, RtE_d, WriteRegE_q, WriteRegE_d;
   logic                RegWriteE_q, RegWriteE_d, MemtoRegE_q, MemtoRegE_d;
   logic                ValidE_q, ValidE_d;
   logic [4:0]          WriteRegM_q, WriteRegM_d;
   logic                RegWriteM_q, RegWriteM_d, MemtoRegM_q, MemtoRegM_d;
   logic                ValidM_q, ValidM_d;
   logic [4:0]          WriteRegW_q, WriteRegW_d;
   logic                RegWriteW_q, RegWriteW_d, ValidW_q, ValidW_d;
   logic [CNT_W-1:0]    md_cnt_q, md_cnt_d;
   logic [RETIRE_W-1:0] RetireCount_q, RetireCount_d;
   logic                md_stall;

   assign md_stall = (md_cnt_q != '0);

   always_comb begin
      RsE_d       = RsE_q;
      RtE_d       = RtE_q;
      WriteRegE_d = WriteRegE_q;
      RegWriteE_d = RegWriteE_q;
      MemtoRegE_d = MemtoRegE_q;
      ValidE_d    = ValidE_q;
      md_cnt_d    = md_cnt_q;
      // A running mul/div owns E: it outranks the hazard unit's flush.
      if (md_stall) begin
         md_cnt_d = md_cnt_q - CNT_W'(1);
      end else if (FlushE_i) begin
         RsE_d       = '0;
         RtE_d       = '0;
         WriteRegE_d = '0;
         RegWriteE_d = 1'b0;
         MemtoRegE_d = 1'b0;
         ValidE_d    = 1'b0;
      end else begin
         RsE_d       = RsD_i;
         RtE_d       = RtD_i;
         WriteRegE_d = WriteRegD_i;
         RegWriteE_d = RegWriteD_i;
         MemtoRegE_d = MemtoRegD_i;
         ValidE_d    = 1'b1;
         if (MulDivD_i) md_cnt_d = MD_LOAD;
      end

      WriteRegM_d = md_stall ? 5'd0 : WriteRegE_q;
      RegWriteM_d = md_stall ? 1'b0 : RegWriteE_q;
      MemtoRegM_d = md_stall ? 1'b0 : MemtoRegE_q;
      ValidM_d    = md_stall ? 1'b0 : ValidE_q;

      WriteRegW_d = WriteRegM_q;
      RegWriteW_d = RegWriteM_q;
      ValidW_d    = ValidM_q;

      RetireCount_d = ValidW_q ? RetireCount_q + RETIRE_W'(1) : RetireCount_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         RsE_q         <= '0;
         RtE_q         <= '0;
         WriteRegE_q   <= '0;
         RegWriteE_q   <= 1'b0;
         MemtoRegE_q   <= 1'b0;
         ValidE_q      <= 1'b0;
         WriteRegM_q   <= '0;
         RegWriteM_q   <= 1'b0;
         MemtoRegM_q   <= 1'b0;
         ValidM_q      <= 1'b0;
         WriteRegW_q   <= '0;
         RegWriteW_q   <= 1'b0;
         ValidW_q      <= 1'b0;
         md_cnt_q      <= '0;
         RetireCount_q <= '0;
      end else begin
         RsE_q         <= RsE_d;
         RtE_q         <= RtE_d;
         WriteRegE_q   <= WriteRegE_d;
         RegWriteE_q   <= RegWriteE_d;
         MemtoRegE_q   <= MemtoRegE_d;
         ValidE_q      <= ValidE_d;
         WriteRegM_q   <= WriteRegM_d;
         RegWriteM_q   <= RegWriteM_d;
         MemtoRegM_q   <= MemtoRegM_d;
         ValidM_q      <= ValidM_d;
         WriteRegW_q   <= WriteRegW_d;
         RegWriteW_q   <= RegWriteW_d;
         ValidW_q      <= ValidW_d;
         md_cnt_q      <= md_cnt_d;
         RetireCount_q <= RetireCount_d;
      end
   end

   assign RsE_o         = RsE_q;
   assign RtE_o         = RtE_q;
   assign WriteRegE_o   = WriteRegE_q;
   assign RegWriteE_o   = RegWriteE_q;
   assign MemtoRegE_o   = MemtoRegE_q;
   assign WriteRegM_o   = WriteRegM_q;
   assign RegWriteM_o   = RegWriteM_q;
   assign MemtoRegM_o   = MemtoRegM_q;
   assign WriteRegW_o   = WriteRegW_q;
   assign RegWriteW_o   = RegWriteW_q;
   assign RetireCount_o = RetireCount_q;
   assign MdStall_o     = md_stall;
   assign EnF_o         = ~(StallF_i | md_stall);
   assign EnD_o         = ~(StallD_i | md_stall);
   assign ClrD_o        = PCSrcD_i & EnD_o;

endmodule

`default_nettype wire
